// File: rtl/frequency_hopper_axil_pkg.sv
// Shared types and helpers for the frequency_hopper AXI4-Lite register bank:
// response codes, channel FSM states, register map indices and byte-strobe merge.
package frequency_hopper_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int REG_CTRL   = 0;
  localparam int REG_SEED   = 1;
  localparam int REG_DWELL  = 2;
  localparam int REG_STATUS = 3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Merge write data into the old register value, one byte lane per strobe bit.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/frequency_hopper_axil_regs.sv
// AXI4-Lite slave register bank feeding the frequency_hopper core (reg_o, wr_pulse_o).
// Define FH_AXIL_SLVERR_EN to answer accesses to unimplemented slots with SLVERR instead of OKAY.
module frequency_hopper_axil_regs
  import frequency_hopper_axil_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 5,
  parameter int          NUM_REGS   = 4,
  parameter logic [31:0] RESET_VAL  = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic [ADDR_WIDTH-1:0]        S_AWADDR,
  input  logic [2:0]                   S_AWPROT,
  input  logic                         S_AWVALID,
  output logic                         S_AWREADY,
  input  logic [DATA_WIDTH-1:0]        S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]      S_WSTRB,
  input  logic                         S_WVALID,
  output logic                         S_WREADY,
  output logic [1:0]                   S_BRESP,
  output logic                         S_BVALID,
  input  logic                         S_BREADY,
  input  logic [ADDR_WIDTH-1:0]        S_ARADDR,
  input  logic [2:0]                   S_ARPROT,
  input  logic                         S_ARVALID,
  output logic                         S_ARREADY,
  output logic [DATA_WIDTH-1:0]        S_RDATA,
  output logic [1:0]                   S_RRESP,
  output logic                         S_RVALID,
  input  logic                         S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int SLOT_W = ADDR_WIDTH - 2;

`ifdef FH_AXIL_SLVERR_EN
  localparam logic [1:0] MISS_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

  function automatic logic in_range(input logic [SLOT_W-1:0] slot);
    return int'(slot) < NUM_REGS;
  endfunction

  wr_state_t                 wr_state;
  rd_state_t                 rd_state;
  logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
  logic [SLOT_W-1:0]         aw_slot_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH/8-1:0]   wstrb_q;

  logic                      aw_hs, w_hs, ar_hs;
  logic                      commit, cm_hit;
  logic [SLOT_W-1:0]         cm_slot;
  logic [DATA_WIDTH-1:0]     cm_data;
  logic [DATA_WIDTH/8-1:0]   cm_strb;
  logic [SLOT_W-1:0]         ar_slot;
  logic [DATA_WIDTH-1:0]     rd_word;

  wire unused_ok = ^{S_AWPROT, S_ARPROT, S_AWADDR[1:0], S_ARADDR[1:0]};

  assign aw_hs   = S_AWVALID & S_AWREADY;
  assign w_hs    = S_WVALID & S_WREADY;
  assign ar_hs   = S_ARVALID & S_ARREADY;
  assign ar_slot = S_ARADDR[ADDR_WIDTH-1:2];

  // Commit source: live channel inputs, or whichever half was latched earlier.
  always_comb begin
    commit  = 1'b0;
    cm_slot = S_AWADDR[ADDR_WIDTH-1:2];
    cm_data = S_WDATA;
    cm_strb = S_WSTRB;
    case (wr_state)
      W_IDLE:      commit = aw_hs & w_hs;
      W_WAIT_DATA: begin
        commit  = w_hs;
        cm_slot = aw_slot_q;
      end
      W_WAIT_ADDR: begin
        commit  = aw_hs;
        cm_data = wdata_q;
        cm_strb = wstrb_q;
      end
      default: ;
    endcase
    cm_hit = in_range(cm_slot);
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_slot == SLOT_W'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_state  <= W_IDLE;
      S_AWREADY <= 1'b0;
      S_WREADY  <= 1'b0;
      S_BVALID  <= 1'b0;
      S_BRESP   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          S_AWREADY <= 1'b1;
          S_WREADY  <= 1'b1;
          if (commit) begin
            wr_state  <= W_RESP;
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b1;
            S_BRESP   <= cm_hit ? RESP_OKAY : MISS_RESP;
          end else if (aw_hs) begin
            wr_state  <= W_WAIT_DATA;
            S_AWREADY <= 1'b0;
          end else if (w_hs) begin
            wr_state  <= W_WAIT_ADDR;
            S_WREADY  <= 1'b0;
          end
        end
        W_WAIT_DATA, W_WAIT_ADDR: begin
          if (commit) begin
            wr_state  <= W_RESP;
            S_AWREADY <= 1'b0;
            S_WREADY  <= 1'b0;
            S_BVALID  <= 1'b1;
            S_BRESP   <= cm_hit ? RESP_OKAY : MISS_RESP;
          end
        end
        W_RESP: begin
          if (S_BREADY) begin
            wr_state  <= W_IDLE;
            S_BVALID  <= 1'b0;
            S_AWREADY <= 1'b1;
            S_WREADY  <= 1'b1;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Half-transaction holding registers; only meaningful while the FSM waits.
  always_ff @(posedge ACLK) begin
    if (wr_state == W_IDLE && !commit) begin
      if (aw_hs) aw_slot_q <= S_AWADDR[ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= S_WDATA;
        wstrb_q <= S_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_pulse_o <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_pulse_o[i] <= commit && cm_hit && (cm_slot == SLOT_W'(i));
        if (commit && cm_hit && (cm_slot == SLOT_W'(i)))
          regs[i] <= apply_wstrb(regs[i], cm_data, cm_strb);
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rd_state  <= R_IDLE;
      S_ARREADY <= 1'b0;
      S_RVALID  <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: begin
          S_ARREADY <= 1'b1;
          if (ar_hs) begin
            rd_state  <= R_DATA;
            S_ARREADY <= 1'b0;
            S_RVALID  <= 1'b1;
            S_RDATA   <= rd_word;
            S_RRESP   <= in_range(ar_slot) ? RESP_OKAY : MISS_RESP;
          end
        end
        R_DATA: begin
          if (S_RREADY) begin
            rd_state  <= R_IDLE;
            S_RVALID  <= 1'b0;
            S_ARREADY <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_o[DATA_WIDTH*g +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_frequency_hopper_axil_regs.sv
// Directed bench for frequency_hopper_axil_regs: handshakes, strobes, split AW/W, backpressure,
// unimplemented slots and reset abort. Honours FH_AXIL_SLVERR_EN for the expected response code.
module tb_frequency_hopper_axil_regs;

`ifdef FH_AXIL_SLVERR_EN
  localparam logic [1:0] EXP_MISS = 2'b10;
`else
  localparam logic [1:0] EXP_MISS = 2'b00;
`endif

  logic         ACLK = 1'b0;
  logic         ARESET = 1'b1;
  logic [4:0]   S_AWADDR = '0;
  logic [2:0]   S_AWPROT = '0;
  logic         S_AWVALID = 1'b0;
  logic         S_AWREADY;
  logic [31:0]  S_WDATA = '0;
  logic [3:0]   S_WSTRB = '0;
  logic         S_WVALID = 1'b0;
  logic         S_WREADY;
  logic [1:0]   S_BRESP;
  logic         S_BVALID;
  logic         S_BREADY = 1'b0;
  logic [4:0]   S_ARADDR = '0;
  logic [2:0]   S_ARPROT = '0;
  logic         S_ARVALID = 1'b0;
  logic         S_ARREADY;
  logic [31:0]  S_RDATA;
  logic [1:0]   S_RRESP;
  logic         S_RVALID;
  logic         S_RREADY = 1'b0;
  logic [127:0] reg_o;
  logic [3:0]   wr_pulse_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 ACLK = ~ACLK;

  frequency_hopper_axil_regs #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4), .RESET_VAL(32'h0)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // All tasks are entered and left at a falling edge.
  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit   aw_done, w_done, aw_hs, w_hs;
    int   cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = S_AWVALID && S_AWREADY;
      w_hs  = S_WVALID && S_WREADY;
      @(negedge ACLK); cyc++;
      if (aw_hs) begin aw_done = 1; S_AWVALID = 1'b0; end
      if (w_hs)  begin w_done = 1;  S_WVALID = 1'b0; end
    end
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    while (!S_BVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
    check("write_bvalid", S_BVALID, 1'b1);
    resp = S_BRESP;
    @(negedge ACLK);
    S_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    cyc = 0;
    S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b1;
    while (!S_ARREADY && cyc < 20) begin @(negedge ACLK); cyc++; end
    @(negedge ACLK);
    S_ARVALID = 1'b0;
    while (!S_RVALID && cyc < 20) begin @(negedge ACLK); cyc++; end
    check("read_rvalid", S_RVALID, 1'b1);
    data = S_RDATA; resp = S_RRESP;
    @(negedge ACLK);
    S_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   resp;
    logic [31:0]  rd;
    logic [127:0] exp_regs;

    repeat (3) @(negedge ACLK);
    check("rst_awready", S_AWREADY, 1'b0);
    check("rst_wready",  S_WREADY,  1'b0);
    check("rst_arready", S_ARREADY, 1'b0);
    check("rst_bvalid",  S_BVALID,  1'b0);
    check("rst_rvalid",  S_RVALID,  1'b0);
    check("rst_bresp",   S_BRESP,   2'b00);
    check("rst_rresp",   S_RRESP,   2'b00);
    check("rst_rdata",   S_RDATA,   32'h0);
    check("rst_reg_o",   reg_o,     128'h0);
    check("rst_pulse",   wr_pulse_o, 4'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rel_awready", S_AWREADY, 1'b1);
    check("rel_wready",  S_WREADY,  1'b1);
    check("rel_arready", S_ARREADY, 1'b1);

    // Basic write then read-back of every implemented register
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), 32'(i + 1), 4'hF, resp);
      check("basic_bresp", resp, 2'b00);
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(5'(i * 4), rd, resp);
      check("basic_rdata", rd, 32'(i + 1));
      check("basic_rresp", resp, 2'b00);
    end
    exp_regs = {32'd4, 32'd3, 32'd2, 32'd1};
    check("basic_reg_o", reg_o, exp_regs);

    // Byte-strobe write with BREADY held low
    S_AWADDR = 5'h00; S_WDATA = 32'hAABBCCDD; S_WSTRB = 4'b0010;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge ACLK);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("strb_bvalid", S_BVALID, 1'b1);
    check("strb_pulse",  wr_pulse_o, 4'b0001);
    check("strb_reg0",   reg_o[31:0], 32'h0000CC01);
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      check("hold_bvalid",  S_BVALID,  1'b1);
      check("hold_bresp",   S_BRESP,   2'b00);
      check("hold_awready", S_AWREADY, 1'b0);
      check("hold_wready",  S_WREADY,  1'b0);
      check("hold_pulse",   wr_pulse_o, 4'b0000);
    end
    S_BREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0;
    check("hold_bvalid_drop", S_BVALID,  1'b0);
    check("hold_awready_back", S_AWREADY, 1'b1);
    axi_read(5'h00, rd, resp);
    check("strb_readback", rd, 32'h0000CC01);
    exp_regs[31:0] = 32'h0000CC01;

    // W arrives before AW to slot 2
    S_WDATA = 32'h12345678; S_WSTRB = 4'hF; S_WVALID = 1'b1;
    @(negedge ACLK);
    S_WVALID = 1'b0;
    check("wfirst_wready",  S_WREADY,  1'b0);
    check("wfirst_awready", S_AWREADY, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      check("wfirst_wait_wready", S_WREADY, 1'b0);
      check("wfirst_wait_bvalid", S_BVALID, 1'b0);
      check("wfirst_wait_pulse",  wr_pulse_o, 4'b0000);
    end
    S_AWADDR = 5'h08; S_AWVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge ACLK);
    S_AWVALID = 1'b0;
    check("wfirst_bvalid", S_BVALID, 1'b1);
    check("wfirst_pulse",  wr_pulse_o, 4'b0100);
    check("wfirst_reg2",   reg_o[95:64], 32'h12345678);
    S_BREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0;
    check("wfirst_bvalid_drop", S_BVALID, 1'b0);
    check("wfirst_single",      wr_pulse_o, 4'b0000);
    exp_regs[95:64] = 32'h12345678;

    // Unimplemented slot 4
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, resp);
    check("miss_bresp", resp, EXP_MISS);
    check("miss_regs",  reg_o, exp_regs);
    axi_read(5'h10, rd, resp);
    check("miss_rdata", rd, 32'h0);
    check("miss_rresp", resp, EXP_MISS);

    // Read and write to slot 3 on the same edge returns the old value
    S_ARADDR = 5'h0C; S_ARVALID = 1'b1; S_RREADY = 1'b0;
    S_AWADDR = 5'h0C; S_WDATA = 32'h00000099; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge ACLK);
    S_ARVALID = 1'b0; S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("same_rvalid", S_RVALID, 1'b1);
    check("same_rdata",  S_RDATA, 32'd4);
    check("same_reg3",   reg_o[127:96], 32'h99);
    S_BREADY = 1'b1; S_RREADY = 1'b1;
    @(negedge ACLK);
    S_BREADY = 1'b0; S_RREADY = 1'b0;
    check("same_bvalid_drop", S_BVALID, 1'b0);
    check("same_rvalid_drop", S_RVALID, 1'b0);

    // Reset while the write response is pending
    S_AWADDR = 5'h04; S_WDATA = 32'h55; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
    @(negedge ACLK);
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    check("abort_bvalid_pre", S_BVALID, 1'b1);
    check("abort_reg1_pre",   reg_o[63:32], 32'h55);
    ARESET = 1'b1;
    @(negedge ACLK);
    check("abort_bvalid", S_BVALID, 1'b0);
    check("abort_regs",   reg_o, 128'h0);
    check("abort_awready", S_AWREADY, 1'b0);
    check("abort_pulse",  wr_pulse_o, 4'b0000);
    ARESET = 1'b0;
    @(negedge ACLK);
    check("abort_awready_back", S_AWREADY, 1'b1);
    check("abort_wready_back",  S_WREADY,  1'b1);
    axi_read(5'h04, rd, resp);
    check("abort_readback", rd, 32'h0);
    check("abort_rresp",    resp, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
